// File: rtl/mem_access_stage.sv
// Memory access stage: turns an execute-stage result into either a passthrough
// writeback value or an RV32I load/store on a req/gnt/rvalid data bus.
//
//   state | meaning
//   IDLE  | ready for a new execute result
//   REQ   | bus request held until the memory grants it
//   WAIT  | granted, waiting for read data or the store acknowledge
//   RESP  | one-cycle result pulse on valid_o
module mem_access_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DWIDTH-1:0] res_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic              memren_i,
  input  logic              memwen_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              valid_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              err_o,
  output logic              stall_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q;
  logic [3:0]          be_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                we_q;
  logic [1:0]          lane_q;
  logic [2:0]          f3_q;
  logic [DWIDTH-1:0]   data_q;
  logic                err_q;

  logic                accept;
  logic                is_mem;
  logic                access_err;
  logic [3:0]          be_d;
  logic [DWIDTH-1:0]   wdata_d;
  logic [DWIDTH-1:0]   load_fmt;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;

  assign accept = valid_i && (state_q == IDLE);
  assign is_mem = memren_i || memwen_i;

  // Decode illegal accesses; funct3 only matters when a memory op is requested.
  always_comb begin
    access_err = 1'b0;
    if (is_mem) begin
      if (memren_i && memwen_i)                           access_err = 1'b1;
      if (funct3_i == 3'b011 || funct3_i == 3'b110 ||
          funct3_i == 3'b111)                             access_err = 1'b1;
      if (memwen_i && funct3_i[2])                        access_err = 1'b1;
      if (funct3_i[1:0] == 2'b01 && res_i[0])             access_err = 1'b1;
      if (funct3_i[1:0] == 2'b10 && res_i[1:0] != 2'b00)  access_err = 1'b1;
    end
  end

  // Byte enables and lane-replicated store data for the accepted access.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = rs2_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_d    = 4'b0001 << res_i[1:0];
        wdata_d = {4{rs2_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {res_i[1], 1'b0};
        wdata_d = {2{rs2_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = rs2_i;
      end
    endcase
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    rd_byte  = mem_rdata_i[7:0];
    rd_half  = mem_rdata_i[15:0];
    load_fmt = mem_rdata_i;
    case (lane_q)
      2'b01:   rd_byte = mem_rdata_i[15:8];
      2'b10:   rd_byte = mem_rdata_i[23:16];
      2'b11:   rd_byte = mem_rdata_i[31:24];
      default: rd_byte = mem_rdata_i[7:0];
    endcase
    if (lane_q[1]) rd_half = mem_rdata_i[31:16];
    case (f3_q)
      3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_fmt = {24'h0, rd_byte};
      3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_fmt = {16'h0, rd_half};
      default: load_fmt = mem_rdata_i;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (is_mem && !access_err) state_d = REQ;
          else                       state_d = RESP;
        end
      end
      REQ:     if (mem_gnt_i)    state_d = WAIT;
      WAIT:    if (mem_rvalid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding bus transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Access and result registers; bus fields only change on a legal memory accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      lane_q  <= '0;
      f3_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      if (!is_mem) begin
        data_q <= res_i;
        err_q  <= 1'b0;
      end else if (access_err) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end else begin
        addr_q  <= {res_i[AWIDTH-1:2], 2'b00};
        be_q    <= be_d;
        wdata_q <= wdata_d;
        we_q    <= memwen_i;
        lane_q  <= res_i[1:0];
        f3_q    <= funct3_i;
        data_q  <= '0;
        err_q   <= 1'b0;
      end
    end else if (state_q == WAIT && mem_rvalid_i) begin
      data_q <= we_q ? '0 : load_fmt;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign stall_o     = ~ready_o;
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_q && (state_q == REQ);
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign valid_o     = (state_q == RESP);
  assign data_o      = data_q;
  assign err_o       = err_q && (state_q == RESP);

endmodule
